// File: rtl/vga_pkg.sv
// Shared menu types, glyph codes and the menu text table for the menu screen.
// Glyph codes are 7-bit; NKL/NKR/A are the existing bracket and letter codes of the font ROM.
package vga_pkg;

  typedef enum logic [1:0] {
    BROWSE  = 2'd0,
    CONFIRM = 2'd1,
    ACTIVE  = 2'd2
  } menu_state_t;

  localparam int GLYPH_W = 7;
  typedef logic [GLYPH_W-1:0] glyph_t;

  localparam glyph_t NKL = 7'h28;
  localparam glyph_t NKR = 7'h29;
  localparam glyph_t A   = 7'h41;

  localparam glyph_t SPACE        = 7'h20;
  localparam glyph_t BRACKET_L    = NKL;
  localparam glyph_t BRACKET_R    = NKR;
  localparam glyph_t CURSOR_GLYPH = 7'h3E;
  localparam glyph_t ACTIVE_GLYPH = A;

  localparam int MENU_TEXT_ROWS = 16;
  localparam int MENU_TEXT_COLS = 12;

  // Each row is a 12-character string; index 0 is the leftmost character.
  localparam logic [0:MENU_TEXT_COLS-1][7:0] MENU_TEXT [MENU_TEXT_ROWS] = '{
    "START GAME  ",
    "OPTIONS     ",
    "HIGH SCORES ",
    "CREDITS     ",
    "EXIT        ",
    "ITEM 05     ",
    "ITEM 06     ",
    "ITEM 07     ",
    "ITEM 08     ",
    "ITEM 09     ",
    "ITEM 10     ",
    "ITEM 11     ",
    "ITEM 12     ",
    "ITEM 13     ",
    "ITEM 14     ",
    "ITEM 15     "
  };

  function automatic int sel_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic glyph_t menu_glyph(input logic [3:0] row, input logic [3:0] idx);
    if (idx >= 4'd12) begin
      return SPACE;
    end
    return MENU_TEXT[row][idx][GLYPH_W-1:0];
  endfunction

endpackage

// File: rtl/menu_textmenu_sel_if.sv
// Menu text/selection bus: character address and button pulses in, glyph and selection out.
interface menu_textmenu_sel_if #(
  parameter int ROWS   = 4,
  parameter int CODE_W = 7
);

  localparam int SEL_W = vga_pkg::sel_width(ROWS);

  logic [7:0]        char_xy;
  logic              btn_up;
  logic              btn_down;
  logic              btn_select;
  logic              btn_back;
  logic [CODE_W-1:0] char_code;
  logic [SEL_W-1:0]  sel_row;
  logic              sel_valid;
  logic [SEL_W-1:0]  sel_item;
  logic              active;

  modport master (
    output char_xy,
    output btn_up,
    output btn_down,
    output btn_select,
    output btn_back,
    input  char_code,
    input  sel_row,
    input  sel_valid,
    input  sel_item,
    input  active
  );

  modport slave (
    input  char_xy,
    input  btn_up,
    input  btn_down,
    input  btn_select,
    input  btn_back,
    output char_code,
    output sel_row,
    output sel_valid,
    output sel_item,
    output active
  );

endinterface

// File: rtl/menu_cursor_fsm.sv
// Browse/confirm/active state machine with the highlighted-row counter and confirmed-item latch.
// MENU_WRAP_EN: when defined the cursor wraps at the ends, otherwise it saturates.
module menu_cursor_fsm
  import vga_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int SEL_W = sel_width(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_select,
  input  logic             btn_back,
  output logic [SEL_W-1:0] sel_row,
  output logic             sel_valid,
  output logic [SEL_W-1:0] sel_item,
  output logic             active
);

`ifdef MENU_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(ROWS - 1);

  menu_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_row_q, sel_row_d;
  logic [SEL_W-1:0] sel_item_q, sel_item_d;
  logic             sel_valid_q, sel_valid_d;
  logic             active_q, active_d;

  // Select wins over movement, and opposing up/down presses cancel out.
  always_comb begin
    state_d    = state_q;
    sel_row_d  = sel_row_q;
    sel_item_d = sel_item_q;
    case (state_q)
      BROWSE: begin
        if (btn_select) begin
          state_d    = CONFIRM;
          sel_item_d = sel_row_q;
        end else if (btn_up && !btn_down) begin
          if (sel_row_q == '0) begin
            sel_row_d = WRAP_EN ? LAST_ROW : '0;
          end else begin
            sel_row_d = sel_row_q - SEL_W'(1);
          end
        end else if (btn_down && !btn_up) begin
          if (sel_row_q == LAST_ROW) begin
            sel_row_d = WRAP_EN ? '0 : LAST_ROW;
          end else begin
            sel_row_d = sel_row_q + SEL_W'(1);
          end
        end
      end
      CONFIRM: begin
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (btn_back) begin
          state_d = BROWSE;
        end
      end
      default: begin
        state_d = BROWSE;
      end
    endcase
    sel_valid_d = (state_d == CONFIRM);
    active_d    = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BROWSE;
      sel_row_q   <= '0;
      sel_item_q  <= '0;
      sel_valid_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_row_q   <= sel_row_d;
      sel_item_q  <= sel_item_d;
      sel_valid_q <= sel_valid_d;
      active_q    <= active_d;
    end
  end

  assign sel_row   = sel_row_q;
  assign sel_valid = sel_valid_q;
  assign sel_item  = sel_item_q;
  assign active    = active_q;

endmodule

// File: rtl/menu_textmenu_sel.sv
// Menu text source: maps char_xy to a registered glyph code and overlays the selection cursor.
// MENU_WRAP_EN (in menu_cursor_fsm) selects wrapping instead of saturating cursor movement.
module menu_textmenu_sel
  import vga_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 16,
  parameter int CODE_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  menu_textmenu_sel_if.slave  bus
);

  localparam int SEL_W = sel_width(ROWS);

  logic [SEL_W-1:0]  sel_row;
  logic [SEL_W-1:0]  sel_item;
  logic              sel_valid;
  logic              active;
  logic [3:0]        row;
  logic [3:0]        col;
  glyph_t            glyph;
  logic [CODE_W-1:0] char_code_d, char_code_q;

  menu_cursor_fsm #(
    .ROWS  (ROWS),
    .SEL_W (SEL_W)
  ) u_cursor_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (bus.btn_up),
    .btn_down   (bus.btn_down),
    .btn_select (bus.btn_select),
    .btn_back   (bus.btn_back),
    .sel_row    (sel_row),
    .sel_valid  (sel_valid),
    .sel_item   (sel_item),
    .active     (active)
  );

  assign row = bus.char_xy[7:4];
  assign col = bus.char_xy[3:0];

  // Columns 0..3 form the "[>] " prefix; menu text starts at column 4.
  always_comb begin
    glyph = SPACE;
    if ((int'(row) < ROWS) && (int'(col) < COLS)) begin
      case (col)
        4'd0:    glyph = BRACKET_L;
        4'd1:    glyph = (row == 4'(sel_row)) ? (active ? ACTIVE_GLYPH : CURSOR_GLYPH) : SPACE;
        4'd2:    glyph = BRACKET_R;
        4'd3:    glyph = SPACE;
        default: glyph = menu_glyph(row, col - 4'd4);
      endcase
    end
    char_code_d = CODE_W'(glyph);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code_q <= CODE_W'(SPACE);
    end else begin
      char_code_q <= char_code_d;
    end
  end

  assign bus.char_code = char_code_q;
  assign bus.sel_row   = sel_row;
  assign bus.sel_valid = sel_valid;
  assign bus.sel_item  = sel_item;
  assign bus.active    = active;

endmodule

// File: doc/menu_textmenu_sel.md
# menu_textmenu_sel

Parametrised menu text source with a built-in selection cursor. It maps the character-grid address `char_xy` to a glyph code for the font renderer and overlays a cursor marker on the currently highlighted row. It runs a browse/confirm/active state machine driven by single-cycle button pulses. It sits between the button pulse logic and the text/font pipeline of the menu screen, and reports the confirmed item to the game control logic.

## Interface
- `ROWS`, default 4: number of menu items, 1..16.
- `COLS`, default 16: characters per row, 4..16.
- `CODE_W`, default 7: glyph code width.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `char_xy` input 8: `[7:4]` is the row and `[3:0]` is the column.
- `btn_up` input 1: single-cycle pulse; moves the cursor up.
- `btn_down` input 1: single-cycle pulse; moves the cursor down.
- `btn_select` input 1: single-cycle pulse; confirms the highlighted item.
- `btn_back` input 1: single-cycle pulse; leaves ACTIVE.
- `char_code` output CODE_W: registered glyph code.
- `sel_row` output $clog2(ROWS) (minimum 1): currently highlighted row.
- `sel_valid` output 1: one-cycle pulse when an item is confirmed.
- `sel_item` output $clog2(ROWS): confirmed item, held until the next confirm.
- `active` output 1: high while in ACTIVE.

## Operation
- The FSM has three states: BROWSE, CONFIRM and ACTIVE.
- BROWSE:
  - `btn_up` decrements `sel_row`.
  - `btn_down` increments `sel_row`.
  - `btn_select` moves to CONFIRM.
- CONFIRM:
  - Lasts exactly one cycle and then moves to ACTIVE.
  - `sel_valid`=1 in this state.
  - `sel_item` loads `sel_row` on entry.
- ACTIVE:
  - `btn_up`, `btn_down` and `btn_select` are ignored.
  - `btn_back` returns to BROWSE.
  - `sel_row` is unchanged.
- Simultaneous events in BROWSE:
  - `btn_select` has priority; no cursor move occurs that cycle.
  - `btn_up` together with `btn_down` gives no move.
- Glyph map for row r < ROWS and column c < COLS:
  - c=0 gives BRACKET_L and c=2 gives BRACKET_R.
  - c=1 on r == `sel_row` gives CURSOR_GLYPH in BROWSE/CONFIRM and ACTIVE_GLYPH in ACTIVE; on all other rows it gives SPACE.
  - c=3 gives SPACE.
  - c≥4 gives `MENU_TEXT[r][c-4]`.
- Any r ≥ ROWS or c ≥ COLS gives SPACE.

## Timing
- `char_code` has 1-cycle latency from `char_xy`, matching the existing font ROM pipeline.
- A button pulse in cycle n updates `sel_row` and the state at edge n+1.
- The marker move appears in `char_code` for addresses presented from cycle n+1 onward, i.e. visible at edge n+2.
- `sel_valid` is high during the cycle after the `btn_select` edge; `sel_item` is valid in the same cycle.
- Reset values:
  - state = BROWSE, `sel_row`=0, `sel_item`=0.
  - `sel_valid`=0, `active`=0.
  - `char_code`=SPACE.
- Reset takes effect immediately, including mid-CONFIRM; no `sel_valid` pulse is emitted after reset is released.
- Button inputs must be synchronous single-cycle pulses; the block does not debounce them.

## Configuration
- `MENU_WRAP_EN` defined:
  - `btn_up` at row 0 goes to ROWS-1.
  - `btn_down` at ROWS-1 goes to 0.
- `MENU_WRAP_EN` undefined:
  - The cursor saturates at 0 and at ROWS-1.
  - A press at the boundary leaves `sel_row` unchanged.
- ROWS=1: `sel_row` is constant 0 in both modes.

## Structure
- `vga_pkg` holds:
  - `menu_state_t` enum (BROWSE, CONFIRM, ACTIVE).
  - Glyph constants BRACKET_L, BRACKET_R, CURSOR_GLYPH, ACTIVE_GLYPH and SPACE, reusing the existing NKL/NKR/A codes where they apply.
  - `MENU_TEXT` as a 16×12 glyph constant array.
- Sub-module `menu_cursor_fsm` contains the state register, the `sel_row` counter and the `sel_valid`/`sel_item` logic.
- The top level holds the glyph lookup and the `char_code` register.

## Test plan
- Reset with `char_xy`=8'h01 → `char_code`=SPACE during reset. After release, `char_code`=CURSOR_GLYPH one cycle later and `sel_row`=0.
- Two `btn_down` pulses, then read `char_xy`=8'h21 → CURSOR_GLYPH; `char_xy`=8'h01 → SPACE.
- Boundary with ROWS=4 and `sel_row`=0, then `btn_up` → `sel_row`=3 with `MENU_WRAP_EN`, 0 without it.
- Confirm at `sel_row`=2 with `btn_select` → `sel_valid` pulse of exactly 1 cycle, `sel_item`=2, `active`=1, and `char_xy`=8'h21 → ACTIVE_GLYPH.
- In ACTIVE, `btn_down` is ignored (`sel_row` stays 2). `btn_back` → `active`=0 and the marker shows CURSOR_GLYPH again.
- `btn_select` together with `btn_down` at `sel_row`=1 → `sel_item`=1 and no move. Separately, `char_xy`=8'h4F with ROWS=4 → SPACE.
